// File: rtl/mem_line_transfer.sv
// Cache-line mover between cache SRAM and external word bus.
// Optional victim writeback, then optional line fill, one command at a time.
module mem_line_transfer #(
  parameter int SRAM_ADDR_W = 11
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   IN_MC_startRead,
  input  logic                   IN_MC_writeBack,
  input  logic [31:0]            IN_MC_sramAddr,
  input  logic [31:0]            IN_MC_extAddr,
  input  logic [31:0]            IN_MC_extWBAddr,
  input  logic [15:0]            IN_MC_size,
  output logic                   OUT_MC_busy,
  output logic                   OUT_EXT_req,
  output logic                   OUT_EXT_we,
  output logic [31:0]            OUT_EXT_addr,
  output logic [31:0]            OUT_EXT_wdata,
  input  logic                   IN_EXT_ack,
  input  logic [31:0]            IN_EXT_rdata,
  output logic                   OUT_CACHE_ce,
  output logic                   OUT_CACHE_we,
  output logic [SRAM_ADDR_W-1:0] OUT_CACHE_addr,
  output logic [31:0]            OUT_CACHE_wdata,
  input  logic [31:0]            IN_CACHE_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    WB_FETCH,
    WB_LATCH,
    WB_REQ,
    RD_REQ,
    RD_LAST
  } state_t;

  localparam logic [SRAM_ADDR_W-1:0] SRAM_ONE = SRAM_ADDR_W'(1);

  state_t                 state;
  logic [SRAM_ADDR_W-1:0] sram_ptr;
  logic [SRAM_ADDR_W-1:0] line_start;
  logic [31:0]            wb_ptr;
  logic [31:0]            rd_ptr;
  logic [15:0]            count;
  logic [15:0]            size_q;
  logic                   fill_q;

  logic                   cmd;
  logic                   acked;
  logic [15:0]            count_nx;
  logic                   last;
  logic [SRAM_ADDR_W-1:0] sram_nx;
  logic [SRAM_ADDR_W-1:0] cmd_sram;
  logic                   unused_hi;

  assign cmd      = IN_MC_startRead | IN_MC_writeBack;
  assign acked    = IN_EXT_ack & OUT_EXT_req;
  assign count_nx = count + 16'd1;
  assign last     = (count_nx == size_q);
  assign sram_nx  = sram_ptr + SRAM_ONE;
  assign cmd_sram = IN_MC_sramAddr[SRAM_ADDR_W-1:0];

  assign unused_hi = ^IN_MC_sramAddr[31:SRAM_ADDR_W];

  // Busy must rise in the very cycle the command is presented.
  assign OUT_MC_busy = (state != IDLE) |
                       ((state == IDLE) & cmd);

  // Sequencer: all bus and SRAM outputs are registered for the next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= IDLE;
      sram_ptr        <= '0;
      line_start      <= '0;
      wb_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      size_q          <= '0;
      fill_q          <= 1'b0;
      OUT_EXT_req     <= 1'b0;
      OUT_EXT_we      <= 1'b0;
      OUT_EXT_addr    <= '0;
      OUT_EXT_wdata   <= '0;
      OUT_CACHE_ce    <= 1'b0;
      OUT_CACHE_we    <= 1'b0;
      OUT_CACHE_addr  <= '0;
      OUT_CACHE_wdata <= '0;
    end else begin
      OUT_CACHE_ce <= 1'b0;
      OUT_CACHE_we <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd) begin
            line_start <= cmd_sram;
            sram_ptr   <= cmd_sram;
            wb_ptr     <= IN_MC_extWBAddr;
            rd_ptr     <= IN_MC_extAddr;
            size_q     <= IN_MC_size;
            fill_q     <= IN_MC_startRead;
            count      <= '0;
            if (IN_MC_writeBack && IN_MC_size != 16'd0) begin
              state          <= WB_FETCH;
              OUT_CACHE_ce   <= 1'b1;
              OUT_CACHE_addr <= cmd_sram;
            end else if (IN_MC_startRead && IN_MC_size != 16'd0) begin
              state        <= RD_REQ;
              OUT_EXT_req  <= 1'b1;
              OUT_EXT_we   <= 1'b0;
              OUT_EXT_addr <= IN_MC_extAddr;
            end
          end
        end
        WB_FETCH: begin
          state <= WB_LATCH;
        end
        WB_LATCH: begin
          OUT_EXT_wdata <= IN_CACHE_rdata;
          OUT_EXT_req   <= 1'b1;
          OUT_EXT_we    <= 1'b1;
          OUT_EXT_addr  <= wb_ptr;
          state         <= WB_REQ;
        end
        WB_REQ: begin
          if (acked) begin
            OUT_EXT_req <= 1'b0;
            OUT_EXT_we  <= 1'b0;
            wb_ptr      <= wb_ptr + 32'd4;
            sram_ptr    <= sram_nx;
            count       <= count_nx;
            if (last) begin
              if (fill_q) begin
                state        <= RD_REQ;
                OUT_EXT_req  <= 1'b1;
                OUT_EXT_addr <= rd_ptr;
                sram_ptr     <= line_start;
                count        <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              state          <= WB_FETCH;
              OUT_CACHE_ce   <= 1'b1;
              OUT_CACHE_addr <= sram_nx;
            end
          end
        end
        RD_REQ: begin
          if (acked) begin
            OUT_CACHE_ce    <= 1'b1;
            OUT_CACHE_we    <= 1'b1;
            OUT_CACHE_addr  <= sram_ptr;
            OUT_CACHE_wdata <= IN_EXT_rdata;
            sram_ptr        <= sram_nx;
            rd_ptr          <= rd_ptr + 32'd4;
            OUT_EXT_addr    <= rd_ptr + 32'd4;
            count           <= count_nx;
            if (last) begin
              OUT_EXT_req <= 1'b0;
              state       <= RD_LAST;
            end
          end
        end
        RD_LAST: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_line_transfer.sv
// Directed bench for mem_line_transfer.
// Scoreboard queues hold expected bus and SRAM-write traffic.
module tb_mem_line_transfer;

  logic        clk;
  logic        rst;
  logic        start_read;
  logic        write_back;
  logic [31:0] sram_addr;
  logic [31:0] ext_addr_in;
  logic [31:0] ext_wb_addr;
  logic [15:0] size;
  logic        busy;
  logic        req;
  logic        ext_we;
  logic [31:0] ext_addr;
  logic [31:0] ext_wdata;
  logic        ack;
  logic [31:0] ext_rdata;
  logic        ce;
  logic        cwe;
  logic [10:0] caddr;
  logic [31:0] cwdata;
  logic [31:0] cache_rdata;

  int checks   = 0;
  int failures = 0;

  int   ack_wait  = 0;
  logic ack_force = 1'b0;
  int   wcnt      = 0;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } ext_t;

  ext_t        ext_q[$];
  logic [42:0] sram_q[$];

  mem_line_transfer #(.SRAM_ADDR_W(11)) dut (
    .clk             (clk),
    .rst             (rst),
    .IN_MC_startRead (start_read),
    .IN_MC_writeBack (write_back),
    .IN_MC_sramAddr  (sram_addr),
    .IN_MC_extAddr   (ext_addr_in),
    .IN_MC_extWBAddr (ext_wb_addr),
    .IN_MC_size      (size),
    .OUT_MC_busy     (busy),
    .OUT_EXT_req     (req),
    .OUT_EXT_we      (ext_we),
    .OUT_EXT_addr    (ext_addr),
    .OUT_EXT_wdata   (ext_wdata),
    .IN_EXT_ack      (ack),
    .IN_EXT_rdata    (ext_rdata),
    .OUT_CACHE_ce    (ce),
    .OUT_CACHE_we    (cwe),
    .OUT_CACHE_addr  (caddr),
    .OUT_CACHE_wdata (cwdata),
    .IN_CACHE_rdata  (cache_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] ext_data(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // External slave: data is a function of address; ack after ack_wait cycles.
  assign ext_rdata = ext_data(ext_addr);
  assign ack = ack_force | (req && (wcnt >= ack_wait));

  always @(posedge clk) begin
    if (req && !ack) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // SRAM: one-cycle read latency; line at 0x80 holds 0xAAAA0000, 0xAAAA0001.
  always @(posedge clk) begin
    if (ce && !cwe) cache_rdata <= {16'hAAAA, 16'(caddr - 11'h080)};
  end

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (req && ack) begin
        checks++;
        assert (ext_q.size() != 0) else begin
          failures++;
          $error("FAIL ext_unexpected observed=%0h expected=none", ext_addr);
        end
        if (ext_q.size() != 0)
          chk("ext_txn", {ext_we, ext_addr, ext_we ? ext_wdata : 32'h0},
              ext_q.pop_front());
      end
      if (ce && cwe) begin
        checks++;
        assert (sram_q.size() != 0) else begin
          failures++;
          $error("FAIL sram_unexpected observed=%0h expected=none", caddr);
        end
        if (sram_q.size() != 0)
          chk("sram_wr", {caddr, cwdata}, sram_q.pop_front());
      end
    end
  end

  task automatic cyc(input string t, input int c, input logic b,
                     input logic r, input logic w, input logic [31:0] a,
                     input logic ce_e, input logic cwe_e,
                     input logic [10:0] ca);
    logic [127:0] obs;
    logic [127:0] exp;
    obs = {busy, req, req ? ext_we : 1'b0, req ? ext_addr : 32'h0,
           ce, ce ? cwe : 1'b0, ce ? caddr : 11'h0};
    exp = {b, r, r ? w : 1'b0, r ? a : 32'h0,
           ce_e, ce_e ? cwe_e : 1'b0, ce_e ? ca : 11'h0};
    chk($sformatf("%s_c%0d", t, c), obs, exp);
  endtask

  task automatic cmd(input logic sr, input logic wb, input logic [31:0] sa,
                     input logic [31:0] ea, input logic [31:0] wba,
                     input logic [15:0] sz);
    @(posedge clk);
    #1;
    start_read  = sr;
    write_back  = wb;
    sram_addr   = sa;
    ext_addr_in = ea;
    ext_wb_addr = wba;
    size        = sz;
    @(negedge clk);
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    start_read = 1'b0;
    write_back = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_idle(input string t);
    for (int i = 0; i < 200 && busy; i++) adv();
    chk(t, {127'h0, busy}, 128'h0);
  endtask

  task automatic push_rd(input logic [31:0] ea, input logic [10:0] sa,
                         input int n);
    for (int i = 0; i < n; i++) begin
      ext_q.push_back({1'b0, ea + 32'(4 * i), 32'h0});
      sram_q.push_back({sa + 11'(i), ext_data(ea + 32'(4 * i))});
    end
  endtask

  initial begin
    rst         = 1'b0;
    start_read  = 1'b0;
    write_back  = 1'b0;
    sram_addr   = '0;
    ext_addr_in = '0;
    ext_wb_addr = '0;
    size        = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {busy, req, ext_we, ext_addr, ext_wdata, ce, cwe,
                       caddr, cwdata}, 128'h0);
    @(negedge clk);
    rst = 1'b1;

    // Fill, zero-wait slave.
    push_rd(32'h1000, 11'h040, 4);
    cmd(1'b1, 1'b0, 32'h40, 32'h1000, 32'h0, 16'd4);
    cyc("fill", 0, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("fill", 1, 1, 1, 0, 32'h1000, 0, 0, 0);
    adv(); cyc("fill", 2, 1, 1, 0, 32'h1004, 1, 1, 11'h040);
    adv(); cyc("fill", 3, 1, 1, 0, 32'h1008, 1, 1, 11'h041);
    adv(); cyc("fill", 4, 1, 1, 0, 32'h100C, 1, 1, 11'h042);
    adv(); cyc("fill", 5, 1, 0, 0, 0, 1, 1, 11'h043);
    adv(); cyc("fill", 6, 0, 0, 0, 0, 0, 0, 0);
    chk("fill_sb_empty", 128'(ext_q.size() + sram_q.size()), 128'h0);

    // Writeback only; ack held high also outside req cycles.
    ack_force = 1'b1;
    ext_q.push_back({1'b1, 32'h2000, 32'hAAAA0000});
    ext_q.push_back({1'b1, 32'h2004, 32'hAAAA0001});
    cmd(1'b0, 1'b1, 32'h80, 32'h0, 32'h2000, 16'd2);
    cyc("wb", 0, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("wb", 1, 1, 0, 0, 0, 1, 0, 11'h080);
    adv(); cyc("wb", 2, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("wb", 3, 1, 1, 1, 32'h2000, 0, 0, 0);
    adv(); cyc("wb", 4, 1, 0, 0, 0, 1, 0, 11'h081);
    adv(); cyc("wb", 5, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("wb", 6, 1, 1, 1, 32'h2004, 0, 0, 0);
    adv(); cyc("wb", 7, 0, 0, 0, 0, 0, 0, 0);
    ack_force = 1'b0;
    chk("wb_sb_empty", 128'(ext_q.size() + sram_q.size()), 128'h0);

    // Writeback then fill of the same SRAM line.
    ext_q.push_back({1'b1, 32'h2000, 32'hAAAA0000});
    ext_q.push_back({1'b1, 32'h2004, 32'hAAAA0001});
    push_rd(32'h1800, 11'h080, 2);
    cmd(1'b1, 1'b1, 32'h80, 32'h1800, 32'h2000, 16'd2);
    cyc("wbf", 0, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("wbf", 1, 1, 0, 0, 0, 1, 0, 11'h080);
    adv(); cyc("wbf", 2, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("wbf", 3, 1, 1, 1, 32'h2000, 0, 0, 0);
    adv(); cyc("wbf", 4, 1, 0, 0, 0, 1, 0, 11'h081);
    adv(); cyc("wbf", 5, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("wbf", 6, 1, 1, 1, 32'h2004, 0, 0, 0);
    adv(); cyc("wbf", 7, 1, 1, 0, 32'h1800, 0, 0, 0);
    adv(); cyc("wbf", 8, 1, 1, 0, 32'h1804, 1, 1, 11'h080);
    adv(); cyc("wbf", 9, 1, 0, 0, 0, 1, 1, 11'h081);
    adv(); cyc("wbf", 10, 0, 0, 0, 0, 0, 0, 0);
    chk("wbf_sb_empty", 128'(ext_q.size() + sram_q.size()), 128'h0);

    // Wait states, with both external and SRAM address wrap.
    ack_wait = 3;
    push_rd(32'hFFFFFFFC, 11'h7FF, 2);
    cmd(1'b1, 1'b0, 32'h7FF, 32'hFFFFFFFC, 32'h0, 16'd2);
    cyc("ws", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 4; c++) begin
      adv(); cyc("ws", c, 1, 1, 0, 32'hFFFFFFFC, 0, 0, 0);
    end
    adv(); cyc("ws", 5, 1, 1, 0, 32'h0, 1, 1, 11'h7FF);
    for (int c = 6; c <= 8; c++) begin
      adv(); cyc("ws", c, 1, 1, 0, 32'h0, 0, 0, 0);
    end
    adv(); cyc("ws", 9, 1, 0, 0, 0, 1, 1, 11'h000);
    adv(); cyc("ws", 10, 0, 0, 0, 0, 0, 0, 0);
    ack_wait = 0;
    chk("ws_sb_empty", 128'(ext_q.size() + sram_q.size()), 128'h0);

    // Zero-length command; stray ack must be ignored.
    ack_force = 1'b1;
    cmd(1'b1, 1'b0, 32'h10, 32'h5000, 32'h0, 16'd0);
    cyc("sz0", 0, 1, 0, 0, 0, 0, 0, 0);
    for (int c = 1; c <= 3; c++) begin
      adv(); cyc("sz0", c, 0, 0, 0, 0, 0, 0, 0);
    end
    ack_force = 1'b0;

    // Asynchronous reset in the middle of a fill.
    push_rd(32'h3000, 11'h100, 4);
    cmd(1'b1, 1'b0, 32'h100, 32'h3000, 32'h0, 16'd4);
    cyc("rstf", 0, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("rstf", 1, 1, 1, 0, 32'h3000, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_async", {busy, req, ext_we, ext_addr, ext_wdata, ce, cwe,
                      caddr, cwdata}, 128'h0);
    ext_q.delete();
    sram_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    push_rd(32'h3000, 11'h100, 2);
    cmd(1'b1, 1'b0, 32'h100, 32'h3000, 32'h0, 16'd2);
    cyc("after", 0, 1, 0, 0, 0, 0, 0, 0);
    adv(); cyc("after", 1, 1, 1, 0, 32'h3000, 0, 0, 0);
    adv(); cyc("after", 2, 1, 1, 0, 32'h3004, 1, 1, 11'h100);
    adv(); cyc("after", 3, 1, 0, 0, 0, 1, 1, 11'h101);
    wait_idle("after_idle");
    chk("after_sb_empty", 128'(ext_q.size() + sram_q.size()), 128'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
